// File: rtl/useq_call_stack_if.sv
// Microsequencer call-stack bus: push/pop controls from the microword side,
// return dispatch address and status flags back to the dispatch logic.
interface useq_call_stack_if;
  logic        clken;
  logic        clear;
  logic        call;
  logic        ret;
  logic [0:11] pushADDR;
  logic [0:11] dispRET;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        unf;

  modport master (
    output clken, clear, call, ret, pushADDR,
    input  dispRET, empty, full, ovf, unf
  );

  modport slave (
    input  clken, clear, call, ret, pushADDR,
    output dispRET, empty, full, ovf, unf
  );
endinterface

// File: rtl/useq_call_stack.sv
// KS-10 microsequencer return-address stack: circular buffer of 12-bit
// return addresses whose top feeds the RET dispatch selectors.
module useq_call_stack #(
  parameter int DEPTH = 16,
  parameter int PTRW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  useq_call_stack_if.slave  bus
);

  localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

  logic [0:11]     stack [DEPTH];
  logic [PTRW-1:0] ptr, ptrNxt, wrPtr;
  logic [PTRW:0]   count, countNxt;
  logic            ovf, ovfNxt;
  logic            unf, unfNxt;
  logic            wrEn;
  logic            isEmpty, isFull;

  assign isEmpty = (count == '0);
  assign isFull  = (count == FULL_COUNT);

  // Outputs depend on registered state only, keeping the dispatch path loop-free.
  assign bus.dispRET = isEmpty ? 12'o0000 : stack[ptr];
  assign bus.empty   = isEmpty;
  assign bus.full    = isFull;
  assign bus.ovf     = ovf;
  assign bus.unf     = unf;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    ptrNxt   = ptr;
    countNxt = count;
    ovfNxt   = ovf;
    unfNxt   = unf;
    wrEn     = 1'b0;
    wrPtr    = ptr;
    if (bus.clken) begin
      if (bus.clear) begin
        ptrNxt   = '0;
        countNxt = '0;
        ovfNxt   = 1'b0;
        unfNxt   = 1'b0;
      end else if (bus.call && (!bus.ret || isEmpty)) begin
        // Plain push; return-then-call on an empty stack degenerates to this.
        ptrNxt = ptr + 1'b1;
        wrPtr  = ptr + 1'b1;
        wrEn   = 1'b1;
        if (isFull) ovfNxt   = 1'b1;
        else        countNxt = count + 1'b1;
      end else if (bus.call && bus.ret) begin
        wrEn = 1'b1;
      end else if (bus.ret) begin
        if (isEmpty) begin
          unfNxt = 1'b1;
        end else begin
          ptrNxt   = ptr - 1'b1;
          countNxt = count - 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ptr   <= ptrNxt;
      count <= countNxt;
      ovf   <= ovfNxt;
      unf   <= unfNxt;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are masked while count is zero.
  always_ff @(posedge clk) begin
    if (wrEn) stack[wrPtr] <= bus.pushADDR;
  end

endmodule

// File: tb/tb_useq_call_stack.sv
// Self-checking bench for useq_call_stack: vector table through a scoreboard
// queue, plus hand sequences for overflow wrap and mid-run reset.
module tb_useq_call_stack;

  localparam int DEPTH = 16;

  typedef struct {
    logic        clken, clear, call, ret;
    logic [0:11] addr;
    logic [0:11] expDisp;
    logic        expEmpty, expFull, expOvf, expUnf;
    string       name;
  } vec_t;

  typedef struct {
    logic [0:11] disp;
    logic        empty, full, ovf, unf;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  useq_call_stack_if bus ();

  useq_call_stack #(.DEPTH(DEPTH), .PTRW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  exp_t sb[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %o, required %o", name, act, req);
  endtask

  task automatic checkAll(input exp_t e);
    check({e.name, ".dispRET"}, bus.dispRET, e.disp);
    check({e.name, ".empty"}, {11'd0, bus.empty}, {11'd0, e.empty});
    check({e.name, ".full"},  {11'd0, bus.full},  {11'd0, e.full});
    check({e.name, ".ovf"},   {11'd0, bus.ovf},   {11'd0, e.ovf});
    check({e.name, ".unf"},   {11'd0, bus.unf},   {11'd0, e.unf});
  endtask

  task automatic idle();
    bus.clken = 1'b1; bus.clear = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.pushADDR = 12'o0000;
  endtask

  // Drive one microcycle, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    bus.clken = v.clken; bus.clear = v.clear; bus.call = v.call; bus.ret = v.ret;
    bus.pushADDR = v.addr;
    e.disp = v.expDisp; e.empty = v.expEmpty; e.full = v.expFull;
    e.ovf = v.expOvf; e.unf = v.expUnf; e.name = v.name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, required one pending entry", v.name);
    end else begin
      checkAll(sb.pop_front());
    end
  endtask

  function automatic vec_t mk(input logic ce, cl, ca, re, input logic [0:11] a,
                              input logic [0:11] d, input logic em, fu, ov, un,
                              input string n);
    vec_t v;
    v.clken = ce; v.clear = cl; v.call = ca; v.ret = re; v.addr = a;
    v.expDisp = d; v.expEmpty = em; v.expFull = fu; v.expOvf = ov; v.expUnf = un;
    v.name = n;
    return v;
  endfunction

  initial begin
    exp_t e;
    //             ce cl ca re addr     disp     em fu ov un
    vecs.push_back(mk(1, 0, 1, 0, 12'o0123, 12'o0123, 0, 0, 0, 0, "lifo_push1"));
    vecs.push_back(mk(1, 0, 1, 0, 12'o0456, 12'o0456, 0, 0, 0, 0, "lifo_push2"));
    vecs.push_back(mk(1, 0, 1, 0, 12'o7777, 12'o7777, 0, 0, 0, 0, "lifo_push3"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0456, 0, 0, 0, 0, "lifo_pop1"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0123, 0, 0, 0, 0, "lifo_pop2"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 0, "lifo_pop3"));
    vecs.push_back(mk(1, 0, 1, 0, 12'o0100, 12'o0100, 0, 0, 0, 0, "cr_push1"));
    vecs.push_back(mk(1, 0, 1, 0, 12'o0200, 12'o0200, 0, 0, 0, 0, "cr_push2"));
    vecs.push_back(mk(1, 0, 1, 1, 12'o0300, 12'o0300, 0, 0, 0, 0, "cr_replace"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0100, 0, 0, 0, 0, "cr_pop1"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 0, "cr_pop2"));
    vecs.push_back(mk(1, 0, 1, 1, 12'o0300, 12'o0300, 0, 0, 0, 0, "cr_empty"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 0, "cr_empty_pop"));
    vecs.push_back(mk(1, 0, 1, 0, 12'o0055, 12'o0055, 0, 0, 0, 0, "en_push"));
    vecs.push_back(mk(0, 0, 1, 0, 12'o1111, 12'o0055, 0, 0, 0, 0, "en_off_call"));
    vecs.push_back(mk(0, 0, 0, 1, 12'o0000, 12'o0055, 0, 0, 0, 0, "en_off_ret"));
    vecs.push_back(mk(0, 0, 1, 1, 12'o2222, 12'o0055, 0, 0, 0, 0, "en_off_both"));
    vecs.push_back(mk(0, 1, 0, 0, 12'o0000, 12'o0055, 0, 0, 0, 0, "en_off_clear"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 0, "en_pop"));
    vecs.push_back(mk(1, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 1, "unf_pop"));
    vecs.push_back(mk(0, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 1, "unf_hold"));
    vecs.push_back(mk(1, 1, 1, 0, 12'o4444, 12'o0000, 1, 0, 0, 0, "clear_call"));

    idle();
    #2;
    e = '{disp: 12'o0000, empty: 1, full: 0, ovf: 0, unf: 0, name: "reset"};
    checkAll(e);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) step(vecs[i]);

    // Overflow wrap: 17 pushes into a 16-deep stack, then drain.
    for (int i = 1; i <= 17; i++)
      step(mk(1, 0, 1, 0, 12'(i), 12'(i), 0, (i >= DEPTH), (i == 17), 0,
              $sformatf("ovf_push%0d", i)));
    for (int k = 1; k <= 16; k++)
      step(mk(1, 0, 0, 1, 12'o0000, (k < 16) ? 12'(17 - k) : 12'o0000,
              (k == 16), 0, 1, 0, $sformatf("ovf_pop%0d", k)));

    // Mid-run asynchronous reset after five pushes (ovf still set from above).
    for (int i = 0; i < 5; i++)
      step(mk(1, 0, 1, 0, 12'(8'o40 + i), 12'(8'o40 + i), 0, 0, 1, 0,
              $sformatf("rst_push%0d", i)));
    idle();
    #2 rst_n = 1'b0;
    #1;
    e = '{disp: 12'o0000, empty: 1, full: 0, ovf: 0, unf: 0, name: "midrun_reset"};
    checkAll(e);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 0, 0, 1, 12'o0000, 12'o0000, 1, 0, 0, 1, "post_reset_pop"));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/useq_call_stack.md
# useq_call_stack

Microsequencer subroutine return-address stack for the KS-10 CPU microcontroller. Microinstructions that call a subroutine push a 12-bit return address. Microinstructions that return pop it. The current top of stack is driven to the dispatch logic as the 12-bit return dispatch address `dispRET[0:11]`, where the RET selectors merge it into the next microaddress. This block produces the `dispRET` input that the dispatch mux consumes.

## Interface
- `DEPTH`, 16: number of stack entries; power of two, 4..64.
- `PTRW`, 4: pointer width; equals log2(`DEPTH`).
- `clk`  in  1  CPU clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  microcycle enable; state changes only on `clk` edges with `clken`=1.
- `clear`  in  1  synchronous stack flush on microcode restart. Qualified by `clken`.
- `call`  in  1  push request; `crom` CALL bit, already decoded.
- `ret`  in  1  pop request; decoded from a RET dispatch select.
- `pushADDR`  in  [0:11]  return address to push; the caller's microaddress.
- `dispRET`  out  [0:11]  top-of-stack address to the dispatch mux.
- `empty`  out  1  stack holds 0 entries.
- `full`  out  1  stack holds `DEPTH` entries.
- `ovf`  out  1  sticky overflow flag.
- `unf`  out  1  sticky underflow flag.

## Operation
- **Storage:** a circular buffer of `DEPTH` × 12-bit entries. `ptr[PTRW-1:0]` indexes the top entry. `count` ranges 0..`DEPTH`.
- **Output mapping:**
  - `dispRET` = entry at `ptr` when `count`>0; otherwise 12'o0000.
  - `empty` = (`count`==0).
  - `full` = (`count`==`DEPTH`).
- **Actions:** evaluated on a `clk` edge with `clken`=1, in priority order.
  - `clear`=1: `count`←0, `ptr`←0, `ovf`←0, `unf`←0. `call` and `ret` are ignored this cycle.
  - `call`=1, `ret`=0 (push): `ptr`←`ptr`+1 mod `DEPTH`, and the entry at the new `ptr`←`pushADDR`.
    - Not full: `count`+1.
    - Full: `count` holds at `DEPTH`. The oldest entry is overwritten and lost, and `ovf`←1.
  - `ret`=1, `call`=0 (pop):
    - Not empty: `ptr`←`ptr`−1 mod `DEPTH`, `count`−1.
    - Empty: `ptr` and `count` hold, and `unf`←1.
  - `call`=1, `ret`=1 (return-then-call):
    - Not empty: the entry at `ptr` is replaced by `pushADDR`. `ptr` and `count` are unchanged.
    - Empty: behaves as a plain push. `unf` is not set.
  - Neither `call` nor `ret`: no change.
- **`clken`=0:** all state holds regardless of the other inputs.
- **Flags:** `ovf` and `unf` stay set until `clear` or reset. They do not block further operations.
- **Storage array:** needs no reset. Its contents are invisible while `count`==0 because `dispRET` is forced to 0.

## Timing
- **Reset:** `rst_n` low asynchronously forces `ptr`=0, `count`=0, `ovf`=0, `unf`=0. Outputs immediately become `dispRET`=12'o0000, `empty`=1, `full`=0.
- **Reset release:** operations resume at the first qualified `clk` edge after `rst_n` rises.
- **Reset during operation:** a reset mid-sequence discards all entries. No partial push survives.
- **Output path:** `dispRET`, `empty` and `full` are combinational from registered state only, with no path from `call`, `ret` or `pushADDR`. This keeps the dispatch path free of loops through the microword.
- **Latency:** a push or pop at edge N is visible on `dispRET` after edge N.
  - A RET dispatch in microcycle N uses the top of stack as it stood before that edge.
  - The pop takes effect at the end of cycle N.
- **Throughput:** one push, pop or replace per enabled cycle. No stall or back-pressure exists.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run after 5 pushes, then release → `dispRET`=0000, `empty`=1, `ovf`=0, `unf`=0. A subsequent pop sets `unf`=1.
- **LIFO order:** push 0123, 0456, 7777 with `clken`=1, then pop 3 times.
  - `dispRET` before each pop reads 7777, 0456, 0123.
  - After the final pop: `empty`=1, `dispRET`=0000.
- **Overflow wrap:** push values 1..17 (`DEPTH`=16).
  - After the 16th push: `full`=1, `ovf`=0.
  - After the 17th push: `ovf`=1, `dispRET`=17.
  - Then 16 pops read 17 down to 2; value 1 is lost. `empty`=1 at the end.
- **Simultaneous call and ret:** push 0100 and 0200, then assert `call`+`ret` with `pushADDR`=0300.
  - `dispRET`=0300 and `count` stays 2; the next pop shows 0100.
  - With the stack empty, the same stimulus gives `dispRET`=0300, `count`=1, `unf`=0.
- **Enable and clear:** hold `clken`=0 while toggling `call`, `ret` and `pushADDR` → no change.
  - Then `clear`+`call` with `clken`=1 → `empty`=1, `ovf`=0, `unf`=0, and nothing is pushed.
